// File: rtl/flit_in_inf_pkg.sv
//------------------------------------------------------------------------------
// flit_in_inf_pkg: shared timestamp constants and wrapped time comparison.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package flit_in_inf_pkg;

   localparam int TS_WIDTH_DEF = 16;
   localparam int LATENCY_DEF  = 1;
   localparam int TS_MAX_W     = 32;

   // True when a <= b on a wrapping w-bit time line (MSB of b - a clear).
   function automatic logic ts_wrap_le(input logic [TS_MAX_W-1:0] a,
                                       input logic [TS_MAX_W-1:0] b,
                                       input int                  w);
      logic [TS_MAX_W-1:0] d;
      d = (b - a) >> (w - 1);
      return ~d[0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/flit_in_inf_ts_stage_fifo.sv
//------------------------------------------------------------------------------
// ts_stage_fifo: 2-entry FIFO of stamped flits; push and pop may coincide.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ts_stage_fifo #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         i_push,
   input  logic [W-1:0] i_push_data,
   input  logic         i_pop,
   output logic [W-1:0] o_head,
   output logic [1:0]   o_count
);

   logic [W-1:0] r_mem [2];
   logic         r_rd_ptr;
   logic         r_wr_ptr;
   logic [1:0]   r_cnt;
   logic         w_push;
   logic         w_pop;

   assign w_pop  = i_pop & (r_cnt != 2'd0);
   assign w_push = i_push & ((r_cnt != 2'd2) | w_pop);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_cnt    <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_cnt;

endmodule

`default_nettype wire

// File: rtl/flit_in_inf.sv
//------------------------------------------------------------------------------
// flit_in_inf: stamps incoming flits with their due time and feeds the FQ.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module flit_in_inf
   import flit_in_inf_pkg::*;
#(
   parameter int TS_WIDTH   = TS_WIDTH_DEF,
   parameter int FLIT_WIDTH = 36,
   parameter int LATENCY    = LATENCY_DEF,
   parameter int DEPTH      = 16,
   parameter int CW         = $clog2(DEPTH + 1)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [TS_WIDTH-1:0]   sim_time,
   input  logic                  in_valid,
   input  logic [FLIT_WIDTH-1:0] in_flit,
   output logic                  in_ready,
   output logic                  enq_valid,
   output logic [FLIT_WIDTH-1:0] enq_flit,
   output logic [TS_WIDTH-1:0]   enq_timestamp,
   input  logic                  fq_dequeue,
   output logic [CW-1:0]         fq_count,
   output logic                  late_error
);

   localparam int SW = FLIT_WIDTH + TS_WIDTH;

   logic [TS_WIDTH-1:0] w_stamp;
   logic [SW-1:0]       w_head;
   logic [1:0]          w_stage_cnt;
   logic                w_accept;
   logic                w_deq_ok;
   logic                w_on_time;
   logic [CW-1:0]       r_fq_count;
   logic                r_late;

   assign w_stamp  = sim_time + TS_WIDTH'(LATENCY);
   assign in_ready = (w_stage_cnt != 2'd2);
   assign w_accept = in_valid & in_ready;

   ts_stage_fifo #(
      .W (SW)
   ) u_stage (
      .clock       (clock),
      .reset       (reset),
      .i_push      (w_accept),
      .i_push_data ({in_flit, w_stamp}),
      .i_pop       (enq_valid),
      .o_head      (w_head),
      .o_count     (w_stage_cnt)
   );

   assign enq_flit      = w_head[SW-1:TS_WIDTH];
   assign enq_timestamp = w_head[TS_WIDTH-1:0];
   assign enq_valid     = (w_stage_cnt != 2'd0) & (r_fq_count != CW'(DEPTH));

   // Illegal dequeue on an empty FQ is ignored so the count cannot underflow.
   assign w_deq_ok  = fq_dequeue & (r_fq_count != '0);
   assign w_on_time = ts_wrap_le(TS_MAX_W'(sim_time), TS_MAX_W'(enq_timestamp), TS_WIDTH);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_fq_count <= '0;
         r_late     <= 1'b0;
      end else begin
         case ({enq_valid, w_deq_ok})
            2'b10:   r_fq_count <= r_fq_count + CW'(1);
            2'b01:   r_fq_count <= r_fq_count - CW'(1);
            default: r_fq_count <= r_fq_count;
         endcase
         if (enq_valid && !w_on_time) begin
            r_late <= 1'b1;
         end
      end
   end

   assign fq_count   = r_fq_count;
   assign late_error = r_late;

   a_no_underflow: assert property (@(posedge clock) disable iff (reset)
      !(fq_dequeue && (r_fq_count == '0)));

endmodule

`default_nettype wire
